// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable serial pattern detector.
//   - default configuration constants (pattern, length, overlap, widths)
//   - cfgAction_t: decoded meaning of a configuration write
//   - lenWidth(): width needed to hold a length in 0..maxLen
//   - bitAt(): single bit select at a run-time index, done as a shift
//   - borderLen(): longest proper prefix of a pattern that is also its
//     suffix, which is where an overlapping search restarts after a hit
// Patterns are right-aligned: bit [len-1] arrives first, bit [0] last.
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int         DEF_MAX_LEN     = 8;
  localparam int         DEF_CNT_W       = 8;
  localparam logic [7:0] DEF_RST_PATTERN = 8'b0001_0101;
  localparam int         DEF_RST_LEN     = 5;
  localparam logic       DEF_RST_OVERLAP = 1'b1;

  // Widest pattern the helper functions can handle.
  localparam int HELPER_W = 32;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_ACCEPT,
    CFG_REJECT
  } cfgAction_t;

  // Number of bits needed to represent 0..maxLen.
  function automatic int lenWidth(input int maxLen);
    return $clog2(maxLen + 1);
  endfunction

  // Bit select with a run-time index; out-of-range indices read as 0.
  function automatic logic bitAt(input logic [HELPER_W-1:0] v, input int idx);
    logic [HELPER_W-1:0] shifted;
    shifted = v >> idx;
    return shifted[0];
  endfunction

  // Longest proper border of pattern[len-1:0]. A border of length j means
  // the first j bits received (pattern[len-1 .. len-j]) equal the last j
  // bits received (pattern[j-1 .. 0]).
  function automatic int borderLen(input logic [HELPER_W-1:0] pattern, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < HELPER_W; j++) begin
      if (j < len) begin
        ok = 1'b1;
        for (int i = 0; i < HELPER_W; i++) begin
          if (i < j) begin
            if (bitAt(pattern, len - 1 - i) != bitAt(pattern, j - 1 - i)) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          best = j;
        end
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// ---------------------------------------------------------------------------
// seq_det_next
// Purely combinational next-state evaluator for the pattern detector.
// Ports:
//   i_pattern     right-aligned pattern, bit [len-1] is received first
//   i_len         active pattern length (1..MAX_LEN)
//   i_state       number of pattern bits currently matched (0..len-1)
//   i_x           incoming serial bit
//   o_next_state  longest prefix (capped at len-1) that is a suffix of the
//                 matched prefix followed by i_x
//   o_full_match  state is len-1 and i_x completes the pattern
// On a full match o_next_state equals the pattern's longest proper border,
// but the top level uses its registered copy of that value instead.
// ---------------------------------------------------------------------------
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = lenWidth(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [LEN_W-1:0]   i_state,
  input  logic               i_x,
  output logic [LEN_W-1:0]   o_next_state,
  output logic               o_full_match
);

  logic [HELPER_W-1:0] w_pattern;

  assign w_pattern = HELPER_W'(i_pattern);

  // The candidate sequence is the k matched prefix bits followed by i_x.
  // Candidate lengths are tried from longest to shortest and the first
  // one whose prefix equals the tail of the candidate wins; j = 0 always
  // qualifies, so the search never falls through.
  always_comb begin
    int   k;
    int   lenI;
    int   t;
    logic ok;
    logic found;
    logic candBit;
    k            = int'(i_state);
    lenI         = int'(i_len);
    t            = 0;
    ok           = 1'b0;
    found        = 1'b0;
    candBit      = 1'b0;
    o_next_state = '0;
    for (int j = MAX_LEN - 1; j >= 0; j--) begin
      ok = (j <= k + 1) && (j <= lenI - 1);
      for (int i = 0; i < MAX_LEN; i++) begin
        if (ok && (i < j)) begin
          t       = k + 1 - j + i;
          candBit = (t == k) ? i_x : bitAt(w_pattern, lenI - 1 - t);
          if (candBit != bitAt(w_pattern, lenI - 1 - i)) begin
            ok = 1'b0;
          end
        end
      end
      if (ok && !found) begin
        o_next_state = LEN_W'(j);
        found        = 1'b1;
      end
    end
  end

  assign o_full_match = (int'(i_state) == int'(i_len) - 1) && (i_x == i_pattern[0]);

endmodule

// File: rtl/seq_detector_prog.sv
// ---------------------------------------------------------------------------
// seq_detector_prog
// Runtime-programmable serial bit-pattern detector with a Mealy match flag
// and a saturating match counter.
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_x            serial data bit
//   i_x_valid      i_x is consumed this cycle
//   i_cfg_we       load configuration this cycle (takes priority over i_x)
//   i_cfg_pattern  new pattern, right-aligned, bit [len-1] received first
//   i_cfg_len      new pattern length, legal range 1..MAX_LEN
//   i_cfg_overlap  1 = overlapping matches allowed
//   i_cnt_clr      synchronous clear of the match counter
//   o_match        same-cycle match flag
//   o_match_cnt    saturating count of matches
//   o_state        number of pattern bits currently matched
//   o_cfg_err      one-cycle pulse after a rejected configuration write
// ---------------------------------------------------------------------------
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter int                 LEN_W       = lenWidth(MAX_LEN),
  parameter int                 CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                 RST_LEN     = DEF_RST_LEN,
  parameter logic               RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_x,
  input  logic               i_x_valid,
  input  logic               i_cfg_we,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_cnt_clr,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic [LEN_W-1:0]   o_state,
  output logic               o_cfg_err
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [LEN_W-1:0]   r_border;
  logic [LEN_W-1:0]   r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfgErr;

  logic [LEN_W-1:0]   w_kmpNext;
  logic               w_fullMatch;
  logic               w_match;
  cfgAction_t         w_cfgAction;
  logic [LEN_W-1:0]   w_stateNext;
  logic [LEN_W-1:0]   w_cfgBorder;

  // The restart point for overlapping mode depends only on the pattern, so
  // it is worked out once when a pattern is loaded and kept in r_border.
  assign w_cfgBorder = LEN_W'(borderLen(HELPER_W'(i_cfg_pattern), int'(i_cfg_len)));

  seq_det_next #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_next (
    .i_pattern    (r_pattern),
    .i_len        (r_len),
    .i_state      (r_state),
    .i_x          (i_x),
    .o_next_state (w_kmpNext),
    .o_full_match (w_fullMatch)
  );

  // Classify a configuration write; lengths of 0 or above MAX_LEN cannot
  // describe a pattern and are refused without touching any state.
  always_comb begin
    w_cfgAction = CFG_IDLE;
    if (i_cfg_we) begin
      if ((i_cfg_len != '0) && (int'(i_cfg_len) <= MAX_LEN)) begin
        w_cfgAction = CFG_ACCEPT;
      end else begin
        w_cfgAction = CFG_REJECT;
      end
    end
  end

  // A config write in the same cycle discards the data bit, so the match
  // flag is suppressed whenever i_cfg_we is high. Reset also masks it so
  // nothing downstream sees a stale partial match while reset is held.
  assign w_match = i_rst & i_x_valid & ~i_cfg_we & w_fullMatch;

  // Next matched-prefix length: a legal config write restarts the search,
  // a refused one leaves it alone, and a completed match either jumps to
  // the pattern's border (overlap) or starts over from nothing.
  always_comb begin
    w_stateNext = r_state;
    if (w_cfgAction == CFG_ACCEPT) begin
      w_stateNext = '0;
    end else if (w_cfgAction == CFG_IDLE && i_x_valid) begin
      if (w_fullMatch) begin
        w_stateNext = r_overlap ? r_border : '0;
      end else begin
        w_stateNext = w_kmpNext;
      end
    end
  end

  // Configuration registers; the reset values rebuild the default pattern
  // including its precomputed border.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pattern <= RST_PATTERN;
      r_len     <= LEN_W'(RST_LEN);
      r_overlap <= RST_OVERLAP;
      r_border  <= LEN_W'(borderLen(HELPER_W'(RST_PATTERN), RST_LEN));
    end else if (w_cfgAction == CFG_ACCEPT) begin
      r_pattern <= i_cfg_pattern;
      r_len     <= i_cfg_len;
      r_overlap <= i_cfg_overlap;
      r_border  <= w_cfgBorder;
    end
  end

  // Matched-prefix register and the error pulse for refused writes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= '0;
      r_cfgErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cfgErr <= (w_cfgAction == CFG_REJECT);
    end
  end

  // Saturating match counter; a clear in the same cycle as a match wins
  // and that match is not counted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_match     = w_match;
  assign o_match_cnt = r_cnt;
  assign o_state     = r_state;
  assign o_cfg_err   = r_cfgErr;

endmodule
